// File: rtl/stream_mux_n.sv
// N:1 stream multiplexer: fixed-select or round-robin arbitration feeding a
// single registered output stage with a valid/ready handshake.
module stream_mux_n #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [SELW-1:0]       sel,
    input  logic [NCH*WIDTH-1:0]  in_data,
    input  logic [NCH-1:0]        in_valid,
    output logic [NCH-1:0]        in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SELW-1:0]       out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam logic [SELW:0]   NCH_L  = (SELW+1)'(NCH);
    localparam logic [SELW-1:0] LAST_L = SELW'(NCH - 1);

    logic [SELW-1:0]  ptr_r;
    logic [WIDTH-1:0] data_r;
    logic [SELW-1:0]  ch_r;
    logic             valid_r;

    logic             load_en_s;
    logic             grant_ok_s;
    logic [SELW-1:0]  grant_ch_s;
    logic [SELW-1:0]  idx_s;
    logic             xfer_s;
    logic [WIDTH-1:0] word_s;
    logic [SELW-1:0]  ptr_next_s;

    assign load_en_s = !valid_r | out_ready;

    // Grant selection: explicit select, or first valid channel scanning from ptr
    always_comb begin
        grant_ok_s = 1'b0;
        grant_ch_s = {SELW{1'b0}};
        idx_s      = {SELW{1'b0}};
        if (mode == 1'b0) begin
            grant_ok_s = ({1'b0, sel} < NCH_L);
            grant_ch_s = sel;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                idx_s      = SELW'((int'(ptr_r) + i) % NCH);
                grant_ch_s = (!grant_ok_s && in_valid[idx_s]) ? idx_s : grant_ch_s;
                grant_ok_s = grant_ok_s | in_valid[idx_s];
            end
        end
    end

    // One-hot ready toward the granted producer, suppressed during reset
    always_comb begin
        in_ready = {NCH{1'b0}};
        if (rst_n && load_en_s && grant_ok_s) begin
            in_ready[grant_ch_s] = 1'b1;
        end else begin
            in_ready = {NCH{1'b0}};
        end
    end

    assign xfer_s     = |(in_valid & in_ready);
    assign word_s     = in_data[int'(grant_ch_s)*WIDTH +: WIDTH];
    assign ptr_next_s = (grant_ch_s == LAST_L) ? {SELW{1'b0}} : grant_ch_s + SELW'(1);

    // Output register and round-robin pointer; ptr only moves on round-robin transfers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            data_r  <= {WIDTH{1'b0}};
            ch_r    <= {SELW{1'b0}};
            ptr_r   <= {SELW{1'b0}};
        end else if (xfer_s) begin
            valid_r <= 1'b1;
            data_r  <= word_s;
            ch_r    <= grant_ch_s;
            ptr_r   <= mode ? ptr_next_s : ptr_r;
        end else if (out_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign out_data  = data_r;
    assign out_ch    = ch_r;
    assign out_valid = valid_r;

endmodule
